store_unit: RTL
===============

// Module: store_unit
// PURPOSE
//   Write-side counterpart of the load path's sign/zero-extension: takes a
//   RV64I store (SB/SH/SW/SD) and packs its value into 8-byte-aligned memory writes.
//   Memory writes carry byte strobes. Stores that cross an 8-byte boundary are
//   split into two write beats.
//   Sits between EX/MEM and the data-memory write port; signals completion to WB/commit.
// PARAMETERS
//   DATA_WIDTH  64  datapath width; only 64 is supported (utils_pkg::DATA_WIDTH)
//   SPLIT_EN    1   1: split boundary-crossing stores; 0: reject them with done_err=1, no write
// PORTS
//   clk         in   1   single clock; all state updates on rising edge
//   rst         in   1   synchronous, active-high reset
//   req_valid   in   1   store request valid
//   req_ready   out  1   unit can accept a request (high only in IDLE)
//   req_addr    in   64  byte address of the store
//   req_data    in   64  rs2 value; only the low 2^req_size bytes are used
//   req_size    in   2   0=B, 1=H, 2=W, 3=D (funct3[1:0])
//   mem_wvalid  out  1   write beat valid
//   mem_wready  in   1   memory accepts the write beat
//   mem_waddr   out  64  8-byte-aligned beat address ([2:0]=0)
//   mem_wdata   out  64  lane-positioned write data
//   mem_wstrb   out  8   byte enables; bit i enables mem_wdata[8i+7:8i]
//   mem_bvalid  in   1   write acknowledge, one pulse per accepted beat
//   done_valid  out  1   one-cycle pulse when the store is complete
//   done_err    out  1   valid with done_valid; 1 = rejected, not written
// BEHAVIOUR
//   Reset: FSM=IDLE, req_ready=1, mem_wvalid=0, done_valid=0, done_err=0.
//   Reset: mem_waddr, mem_wdata and mem_wstrb are all 0.
//   Request accept (req_valid & req_ready):
//     - Register off=addr[2:0] and base={addr[63:3],3'b0}.
//     - Register sh128 = zext(data masked to 2^size bytes) << 8*off, 128 bits.
//     - Register st16 = byte_mask(size) << off, 16 bits.
//     - Register two = |st16[15:8].
//   FSM states: IDLE, W0, A0, W1, A1, DONE.
//   IDLE -> W0 on accept; IDLE -> DONE with err=1 if two & !SPLIT_EN.
//   W0: mem_wvalid=1, waddr=base, wdata=sh128[63:0], wstrb=st16[7:0].
//   W0: hold all beat outputs stable until mem_wready; then -> A0.
//   A0: wait for mem_bvalid; then -> W1 if two, else -> DONE.
//   W1: same as W0, with waddr=base+8 (wraps mod 2^64), wdata=sh128[127:64],
//       wstrb=st16[15:8]; on mem_wready -> A1.
//   A1: wait for mem_bvalid, then -> DONE.
//   DONE: done_valid=1 for exactly one cycle, then -> IDLE.
//   A bvalid in the same cycle as wready (W state) is not counted; ack comes in A state.
//   mem_bvalid in IDLE, W0, W1 or DONE is ignored.
//   Latency, aligned store with wready/bvalid each one cycle after assert: accept->done = 4 cycles.
//   Aligned D at off=0: single beat, wstrb=8'hFF.
//   B never splits. H/W/D split iff off+2^size > 8.
//   rst in any state: abandon the in-flight beat immediately, no done pulse, return to IDLE.
//   The memory side is reset by the same rst.
// STRUCTURE
//   utils_pkg gains:
//     - typedef enum logic[1:0] {SZ_B,SZ_H,SZ_W,SZ_D} mem_size_e
//     - function byte_mask(mem_size_e) -> logic[7:0]: 01/03/0F/FF
//     - function data_mask(mem_size_e) -> 64-bit masking, reusing zext_8/16/32
//   Sub-module store_lane_shifter (combinational):
//     - inputs data, size, off
//     - outputs sh128, st16, two
//   FSM state enum is local to store_unit.
// TESTING
//   SB addr=0x1003 data=0xAB -> one beat, waddr=0x1000, wstrb=8'h08, wdata=0x00000000AB000000.
//   SD addr=0x2000 data=0x1122334455667788 -> one beat, wstrb=FF, data unchanged, done_err=0.
//   SW addr=0x3006 data=0xDEADBEEF -> beat0 @0x3000 wstrb=C0 wdata[63:48]=0xBEEF.
//     Same store -> beat1 @0x3008 wstrb=03 wdata[15:0]=0xDEAD, then one done pulse.
//   SH addr=0xFFFF_FFFF_FFFF_FFFF, SPLIT_EN=1 -> beat0 wstrb=80.
//     Same store -> beat1 waddr=0 (wrap), wstrb=01.
//   Same as previous with SPLIT_EN=0 -> no mem_wvalid, done_valid=1 with done_err=1.
//   SD split with mem_wready held low 5 cycles, then rst in A0:
//     - beat outputs stable throughout the stall
//     - after rst: IDLE, req_ready=1, no done pulse

Source files
------------

// File: rtl/utils_pkg.sv
// Shared datapath helpers: access-size encoding, byte masks and zero-extension
// used by both the load and store sides of the memory stage.
package utils_pkg;

  localparam int DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  function automatic logic [63:0] zext_8(input logic [7:0] v);
    return {56'b0, v};
  endfunction

  function automatic logic [63:0] zext_16(input logic [15:0] v);
    return {48'b0, v};
  endfunction

  function automatic logic [63:0] zext_32(input logic [31:0] v);
    return {32'b0, v};
  endfunction

  function automatic logic [7:0] byte_mask(input mem_size_e size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] data_mask(input logic [63:0] data, input mem_size_e size);
    case (size)
      SZ_B:    return zext_8(data[7:0]);
      SZ_H:    return zext_16(data[15:0]);
      SZ_W:    return zext_32(data[31:0]);
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_shifter.sv
// Positions a store's bytes across two adjacent 8-byte lanes and reports
// whether the upper lane is touched (i.e. the store crosses a boundary).
module store_lane_shifter
  import utils_pkg::*;
(
  input  logic [63:0]  data,
  input  mem_size_e    size,
  input  logic [2:0]   off,
  output logic [127:0] sh128,
  output logic [15:0]  st16,
  output logic         two
);

  assign sh128 = {64'b0, data_mask(data, size)} << {off, 3'b000};
  assign st16  = {8'b0, byte_mask(size)} << off;
  assign two   = |st16[15:8];

endmodule

// File: rtl/store_unit.sv
// RV64I store unit: packs SB/SH/SW/SD into aligned, strobed memory write beats,
// splitting boundary-crossing stores into two beats, and reports completion.
module store_unit
  import utils_pkg::*;
#(
  parameter int DATA_WIDTH = utils_pkg::DATA_WIDTH,
  parameter bit SPLIT_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [1:0]            req_size,
  output logic                  mem_wvalid,
  input  logic                  mem_wready,
  output logic [DATA_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [7:0]            mem_wstrb,
  input  logic                  mem_bvalid,
  output logic                  done_valid,
  output logic                  done_err
);

  typedef enum logic [2:0] {S_IDLE, S_W0, S_A0, S_W1, S_A1, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [63:0]    base_q, base_d;
  logic [127:0]   sh128_q, sh128_d;
  logic [15:0]    st16_q, st16_d;
  logic           two_q, two_d;
  logic           err_q, err_d;

  logic [127:0]   sh128_w;
  logic [15:0]    st16_w;
  logic           two_w;
  logic           beat1;

  store_lane_shifter u_shifter (
    .data  (req_data),
    .size  (mem_size_e'(req_size)),
    .off   (req_addr[2:0]),
    .sh128 (sh128_w),
    .st16  (st16_w),
    .two   (two_w)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    base_d  = base_q;
    sh128_d = sh128_q;
    st16_d  = st16_q;
    two_d   = two_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        base_d  = {req_addr[63:3], 3'b000};
        sh128_d = sh128_w;
        st16_d  = st16_w;
        two_d   = two_w;
        err_d   = two_w && !SPLIT_EN;
        state_d = (two_w && !SPLIT_EN) ? S_DONE : S_W0;
      end
      S_W0:    if (mem_wready) state_d = S_A0;
      S_A0:    if (mem_bvalid) state_d = two_q ? S_W1 : S_DONE;
      S_W1:    if (mem_wready) state_d = S_A1;
      S_A1:    if (mem_bvalid) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      sh128_q <= '0;
      st16_q  <= '0;
      two_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      sh128_q <= sh128_d;
      st16_q  <= st16_d;
      two_q   <= two_d;
      err_q   <= err_d;
    end
  end

  // Beat outputs come straight from the captured request, so they are stable while stalled.
  assign beat1      = (state_q == S_W1) || (state_q == S_A1);
  assign req_ready  = (state_q == S_IDLE);
  assign mem_wvalid = (state_q == S_W0) || (state_q == S_W1);
  assign mem_waddr  = beat1 ? base_q + 64'd8 : base_q;
  assign mem_wdata  = beat1 ? sh128_q[127:64] : sh128_q[63:0];
  assign mem_wstrb  = beat1 ? st16_q[15:8] : st16_q[7:0];
  assign done_valid = (state_q == S_DONE);
  assign done_err   = done_valid && err_q;

endmodule
